// File: rtl/corr_pkg.sv
// Constants and FSM state type shared by the gain-correction stages.
package corr_pkg;

  localparam int unsigned CORR_W    = 30;
  localparam int unsigned CORR_FRAC = 29;
  localparam logic [31:0] CORR_D    = 32'h212F0A9F;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StRound,
    StDone
  } corr_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import corr_pkg::*;
#(
  parameter int unsigned W       = CORR_W,
  parameter logic [31:0] DIVISOR = CORR_D
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_trial;
  logic [W:0] w_div;

  assign w_trial = {i_rem, i_bit};
  assign w_div   = DIVISOR[W:0];
  assign o_qbit  = (w_trial >= w_div);
  // Remainder stays below DIVISOR < 2^W, so the top bit is always zero after the subtract.
  assign o_rem   = o_qbit ? W'(w_trial - w_div) : w_trial[W-1:0];

endmodule

// File: rtl/uncorrect_seq.sv
// Sequential inverse of the gain correction: y2 = floor(x2 * 2^FRAC / DIVISOR), bit-serial.
// Define UNCORRECT_ROUND_EN for a round-half-up quotient at the cost of one extra cycle.
module uncorrect_seq
  import corr_pkg::*;
#(
  parameter int unsigned W       = CORR_W,
  parameter int unsigned FRAC    = CORR_FRAC,
  parameter logic [31:0] DIVISOR = CORR_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         x1,
  input  logic [W-1:0] x2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         y1,
  output logic [W-1:0] y2
);

  localparam int unsigned CW = $clog2(W);

  corr_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_src;
  logic [W-2:0]  r_q;
  logic          r_out_valid;
  logic          r_y1;
  logic [W-1:0]  r_y2;

  logic [W-1:0]  w_rem;
  logic          w_qbit;
  logic [W-1:0]  w_q_next;
  logic          w_accept;
  logic          w_last;

  div_step #(
    .W       (W),
    .DIVISOR (DIVISOR)
  ) u_div_step (
    .i_rem  (r_rem),
    .i_bit  (r_src[W-1]),
    .o_rem  (w_rem),
    .o_qbit (w_qbit)
  );

  assign in_ready  = (r_state == StIdle) || ((r_state == StDone) && out_ready);
  assign w_accept  = in_ready && in_valid;
  assign w_q_next  = {r_q, w_qbit};
  assign w_last    = (r_cnt == CW'(W - 1));
  assign out_valid = r_out_valid;
  assign y1        = r_y1;
  assign y2        = r_y2;

`ifdef UNCORRECT_ROUND_EN
  logic w_round_up;
  assign w_round_up = ({r_rem, 1'b0} >= DIVISOR[W:0]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_src       <= '0;
      r_q         <= '0;
      r_out_valid <= 1'b0;
      r_y1        <= 1'b0;
      r_y2        <= '0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (r_state == StDone && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
          // Consuming a result and accepting the next word share one edge.
          if (w_accept) begin
            if (x1) begin
              r_y1        <= 1'b1;
              r_y2        <= x2;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end else begin
              r_rem   <= {1'b0, x2[W-1:1]};
              r_src   <= {x2[0], {FRAC{1'b0}}};
              r_q     <= '0;
              r_cnt   <= '0;
              r_state <= StBusy;
            end
          end
        end
        StBusy: begin
          r_rem <= w_rem;
          r_src <= r_src << 1;
          r_q   <= w_q_next[W-2:0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_y1 <= 1'b0;
            r_y2 <= w_q_next;
`ifdef UNCORRECT_ROUND_EN
            r_state <= StRound;
`else
            r_out_valid <= 1'b1;
            r_state     <= StDone;
`endif
          end
        end
`ifdef UNCORRECT_ROUND_EN
        StRound: begin
          if (w_round_up && !(&r_y2)) begin
            r_y2 <= r_y2 + W'(1);
          end
          r_out_valid <= 1'b1;
          r_state     <= StDone;
        end
`endif
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
